// File: rtl/pkt_tx_sched_if.sv
// Handshake bundle between the softmax engine, the transmit scheduler and
// the UART controller. The scheduler uses the slave view; the surrounding
// logic (engine + UART side) uses the master view.
interface pkt_tx_sched_if #(
    parameter int PKT_W = 128
);
    logic             sm_valid;
    logic [PKT_W-1:0] sm_packet;
    logic             sm_ready;
    logic             uart_valid;
    logic [PKT_W-1:0] uart_data;
    logic             uart_done;

    modport master (
        output sm_valid, sm_packet, uart_done,
        input  sm_ready, uart_valid, uart_data
    );

    modport slave (
        input  sm_valid, sm_packet, uart_done,
        output sm_ready, uart_valid, uart_data
    );
endinterface

// File: rtl/pkt_tx_sched.sv
// pkt_tx_sched: buffers softmax result packets and hands them one at a time
// to the UART controller, waiting for tx completion (or a watchdog expiry)
// before releasing the next one. Transmission is gated by tx_en.
// Optional feature macro: PKT_TX_SCHED_FLUSH_EN adds a 'flush' input that
// empties the buffer and forces the scheduler back to IDLE.
module pkt_tx_sched #(
    parameter int PKT_W       = 128,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    pkt_tx_sched_if.slave              bus,
    input  logic                       tx_en,
`ifdef PKT_TX_SCHED_FLUSH_EN
    input  logic                       flush,
`endif
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 pkt_cnt,
    output logic                       timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [15:0]      wdog_q, wdog_d;
    logic [7:0]       pkt_cnt_q, pkt_cnt_d;
    logic             terr_q, terr_d;

    logic             ready_w;
    logic             push;
    logic             done_ev;
    logic             drop_ev;
    logic             pop;
    logic             flush_ev;

`ifdef PKT_TX_SCHED_FLUSH_EN
    assign flush_ev = flush;
`else
    assign flush_ev = 1'b0;
`endif

    // Ready is taken from the registered count, so a pop cannot free a slot
    // for a same-cycle push when the buffer is full.
    assign ready_w = (level_q != LW'(DEPTH));
    assign push    = bus.sm_valid && ready_w;
    // Completion wins over a watchdog expiry landing in the same cycle.
    assign done_ev = (state_q == WAIT_DONE) && bus.uart_done;
    assign drop_ev = (state_q == WAIT_DONE) && !bus.uart_done &&
                     (wdog_q == 16'(TIMEOUT_CYC - 1));
    assign pop     = done_ev || drop_ev;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start only with data buffered and tx enabled
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (level_q != '0 && tx_en) state_d = LOAD;
            LOAD:      state_d = WAIT_DONE;
            WAIT_DONE: if (pop) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (flush_ev) state_d = IDLE;
    end

    // FSM outputs: one-cycle valid pulse, head held while a packet is in flight
    always_comb begin
        bus.uart_valid = (state_q == LOAD);
        bus.uart_data  = '0;
        if (state_q != IDLE) bus.uart_data = mem_q[rd_ptr_q];
    end

    // Buffer/counter next-state; flush leaves pkt_cnt and timeout_err alone
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        wdog_d    = '0;
        pkt_cnt_d = pkt_cnt_q;
        terr_d    = terr_q;
        if (flush_ev) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
            if (state_q == WAIT_DONE && !pop) wdog_d = wdog_q + 16'd1;
            if (done_ev) pkt_cnt_d = pkt_cnt_q + 8'd1;
            if (drop_ev) terr_d = 1'b1;
        end
    end

    // Buffer/counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            wdog_q    <= '0;
            pkt_cnt_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            wdog_q    <= wdog_d;
            pkt_cnt_q <= pkt_cnt_d;
            terr_q    <= terr_d;
        end
    end

    // Packet storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (push && !flush_ev) mem_q[wr_ptr_q] <= bus.sm_packet;
    end

    assign bus.sm_ready = ready_w;
    assign busy         = (state_q != IDLE) || (level_q != '0);
    assign level        = level_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign timeout_err  = terr_q;
endmodule
